// File: rtl/nibble_serial_add_ctrl.sv
// ----------------------------------------------------------------------------
// nibble_serial_add_ctrl
//
// Bit-serial-by-nibble adder/subtractor. A single 4-bit ripple-carry slice is
// time-shared over NIBBLES cycles, LSB nibble first. Operations are accepted
// with a valid/ready handshake and results are returned the same way.
//
// Ports:
//   clk          in   clock, all state updates on the rising edge
//   rst          in   synchronous active-high reset
//   start_valid  in   requester presents an operation
//   start_ready  out  operation accepted this cycle (IDLE only)
//   op_a, op_b   in   W-bit operands, sampled on accept
//   cin          in   carry-in, sampled on accept, ignored when sub=1
//   sub          in   0: A+B+cin, 1: A-B
//   res_valid    out  result/cout/ovf valid (DONE)
//   res_ready    in   consumer takes the result
//   result       out  W-bit sum/difference, modulo 2^W
//   cout         out  carry out of MSB (for sub, 1 = no borrow)
//   ovf          out  two's-complement overflow
//   busy         out  high whenever not IDLE
// ----------------------------------------------------------------------------
module nibble_serial_add_ctrl #(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_valid,
    output logic                   start_ready,
    input  logic [4*NIBBLES-1:0]   op_a,
    input  logic [4*NIBBLES-1:0]   op_b,
    input  logic                   cin,
    input  logic                   sub,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [4*NIBBLES-1:0]   result,
    output logic                   cout,
    output logic                   ovf,
    output logic                   busy
);

    localparam int unsigned W  = 4 * NIBBLES;
    localparam int unsigned IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    r_state;
    logic [W-1:0]  r_a;
    logic [W-1:0]  r_b;       // already inverted for subtraction
    logic          r_carry;
    logic [IW-1:0] r_idx;
    logic [W-1:0]  r_result;
    logic          r_cout;
    logic          r_ovf;

    // Single 4-bit ripple slice, each full adder built from two half adders.
    logic [3:0] w_na;
    logic [3:0] w_nb;
    logic [3:0] w_sum;
    logic [4:0] w_c;
    logic [3:0] w_hs1;
    logic [3:0] w_hc1;
    logic [3:0] w_hc2;

    always_comb begin
        w_na   = r_a[{r_idx, 2'b00} +: 4];
        w_nb   = r_b[{r_idx, 2'b00} +: 4];
        w_c    = '0;
        w_sum  = '0;
        w_hs1  = '0;
        w_hc1  = '0;
        w_hc2  = '0;
        w_c[0] = r_carry;
        for (int i = 0; i < 4; i++) begin
            w_hs1[i]  = w_na[i] ^ w_nb[i];
            w_hc1[i]  = w_na[i] & w_nb[i];
            w_sum[i]  = w_hs1[i] ^ w_c[i];
            w_hc2[i]  = w_hs1[i] & w_c[i];
            w_c[i+1]  = w_hc1[i] | w_hc2[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_carry  <= 1'b0;
            r_idx    <= '0;
            r_result <= '0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_valid) begin
                        r_a     <= op_a;
                        // A - B computed as A + ~B + 1
                        r_b     <= sub ? ~op_b : op_b;
                        r_carry <= sub | cin;
                        r_idx   <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_result[{r_idx, 2'b00} +: 4] <= w_sum;
                    r_carry <= w_c[4];
                    if (r_idx == LAST_IDX) begin
                        r_cout  <= w_c[4];
                        r_ovf   <= w_c[3] ^ w_c[4];
                        r_idx   <= '0;
                        r_state <= S_DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                S_DONE: begin
                    if (res_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        start_ready = (r_state == S_IDLE);
        res_valid   = (r_state == S_DONE);
        busy        = (r_state != S_IDLE);
        result      = r_result;
        cout        = r_cout;
        ovf         = r_ovf;
    end

endmodule
